// File: rtl/ip_pulse_pacer.sv
// Paces bursty source-domain events into single-cycle pulses spaced 1+GAP cycles
// apart, buffering the backlog in a saturating pending counter.
module ip_pulse_pacer #(
    parameter int GAP   = 6,
    parameter int CNT_W = 4
) (
    input  logic             i_src_clk,
    input  logic             hrst_n,
    input  logic             i_evt,
    input  logic             i_clr,
    output logic             o_src_pulse,
    output logic [CNT_W-1:0] o_pend_cnt,
    output logic             o_overflow,
    output logic             o_busy
);

    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             pulse_q, pulse_d;
    logic             have_evt, consume;

    assign have_evt = (cnt_q != '0) || i_evt;

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        pulse_d = 1'b0;
        consume = 1'b0;

        case (state_q)
            S_IDLE:  consume = have_evt;
            S_PULSE: begin
                state_d = S_GAP;
                gcnt_d  = GW'(GAP - 1);
            end
            S_GAP: begin
                if (gcnt_q == '0) begin
                    if (have_evt) consume = 1'b1;
                    else          state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (consume) begin
            state_d = S_PULSE;
            pulse_d = 1'b1;
        end

        // A consuming cycle with a new event nets to zero, so a full counter never overflows then.
        if (consume) begin
            if (cnt_q != '0 && !i_evt) cnt_d = cnt_q - CNT_W'(1);
        end else if (i_evt) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
        end

        if (i_clr) begin
            state_d = S_IDLE;
            gcnt_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            pulse_d = 1'b0;
        end
    end

    always_ff @(posedge i_src_clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q <= S_IDLE;
            gcnt_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_src_pulse = pulse_q;
    assign o_pend_cnt  = cnt_q;
    assign o_overflow  = ovf_q;
    assign o_busy      = (state_q != S_IDLE) || (cnt_q != '0);

endmodule
